// File: rtl/squash_if.sv
// -----------------------------------------------------------------------------
// squash_if
//   Hazard-control bundle between the hazard/fetch side (master) and the
//   squash controller (slave). Signal prefixes follow the controller's view:
//   i_* flow into the controller and o_* flow out of it.
//
//   i_redirect    taken branch/jump this cycle (level)
//   i_load_use    load-use hazard this cycle (level)
//   i_instr       current fetched instruction word
//   o_squash      zero-select of the instruction input-or-zero mux
//   o_stall       hold PC/fetch (STALL only)
//   o_held_instr  instruction captured at stall entry
//   o_busy        controller not in RUN
// -----------------------------------------------------------------------------
interface squash_if #(
    parameter int WIDTH = 17
);
    logic             i_redirect;
    logic             i_load_use;
    logic [WIDTH-1:0] i_instr;
    logic             o_squash;
    logic             o_stall;
    logic [WIDTH-1:0] o_held_instr;
    logic             o_busy;

    modport master (
        output i_redirect, i_load_use, i_instr,
        input  o_squash, o_stall, o_held_instr, o_busy
    );

    modport slave (
        input  i_redirect, i_load_use, i_instr,
        output o_squash, o_stall, o_held_instr, o_busy
    );
endinterface

// File: rtl/squash_control.sv
// -----------------------------------------------------------------------------
// squash_control
//   Sequential hazard controller driving the zero-select of the instruction
//   input-or-zero mux. A taken redirect produces FLUSH_CYCLES bubbles; a
//   load-use hazard produces STALL_CYCLES of stall-plus-bubble and captures
//   the stalled instruction so fetch can re-issue it.
//
//   Parameters
//     WIDTH         instruction width (must match mux data width)
//     FLUSH_CYCLES  bubble cycles per redirect, 1..15
//     STALL_CYCLES  stall cycles per load-use hazard, 1..15
//
//   Ports
//     i_clk           rising-edge clock
//     i_rst_n         synchronous active-low reset
//     sq_bus          squash_if.slave (redirect/load-use/instr in;
//                     squash/stall/held/busy out, all registered)
//     o_squash_count  saturating count of Squash=1 cycles (only when the
//                     SQUASH_STATS_EN macro is defined)
//
//   Optional feature macro: SQUASH_STATS_EN
// -----------------------------------------------------------------------------
module squash_control #(
    parameter int WIDTH        = 17,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef SQUASH_STATS_EN
    output logic [15:0] o_squash_count,
`endif
    squash_if.slave     sq_bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Counter reload values: the count runs down to zero inclusive, so a
    // reload of N-1 gives exactly N cycles in the state.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_squash;
    logic             r_stall;
    logic             r_busy;
    logic [WIDTH-1:0] r_held;

    logic             w_cnt_done;

    assign w_cnt_done = (r_cnt == 4'd0);

    // Single-process FSM. Outputs are registered alongside the next state so
    // they are glitch-free and line up with the state they decode.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_cnt    <= 4'd0;
            r_squash <= 1'b0;
            r_stall  <= 1'b0;
            r_busy   <= 1'b0;
            r_held   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (sq_bus.i_redirect) begin
                        // Redirect wins over a simultaneous load-use; no capture.
                        r_state  <= ST_FLUSH;
                        r_cnt    <= FLUSH_LOAD;
                        r_squash <= 1'b1;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else if (sq_bus.i_load_use) begin
                        r_state  <= ST_STALL;
                        r_cnt    <= STALL_LOAD;
                        r_squash <= 1'b1;
                        r_stall  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_held   <= sq_bus.i_instr;
                    end else begin
                        r_squash <= 1'b0;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    // Load-use is ignored here; the hazard unit re-raises it in RUN.
                    if (sq_bus.i_redirect) begin
                        r_cnt    <= FLUSH_LOAD;
                        r_squash <= 1'b1;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else if (w_cnt_done) begin
                        r_state  <= ST_RUN;
                        r_squash <= 1'b0;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                    end
                end

                ST_STALL: begin
                    // A redirect abandons the stalled instruction: stall drops
                    // immediately but the held word stays for observation.
                    if (sq_bus.i_redirect) begin
                        r_state  <= ST_FLUSH;
                        r_cnt    <= FLUSH_LOAD;
                        r_squash <= 1'b1;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else if (w_cnt_done) begin
                        r_state  <= ST_RUN;
                        r_squash <= 1'b0;
                        r_stall  <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state  <= ST_RUN;
                    r_cnt    <= 4'd0;
                    r_squash <= 1'b0;
                    r_stall  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign sq_bus.o_squash     = r_squash;
    assign sq_bus.o_stall      = r_stall;
    assign sq_bus.o_busy       = r_busy;
    assign sq_bus.o_held_instr = r_held;

`ifdef SQUASH_STATS_EN
    logic [15:0] r_squash_count;

    // Counts cycles in which the registered Squash output is high; sticks at
    // all-ones rather than wrapping so long runs stay visibly saturated.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_squash_count <= 16'd0;
        end else if (r_squash && (r_squash_count != 16'hFFFF)) begin
            r_squash_count <= r_squash_count + 16'd1;
        end
    end

    assign o_squash_count = r_squash_count;
`endif

endmodule

// File: tb/tb_squash_control.sv
module tb_squash_control;
    localparam int W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    squash_if #(.WIDTH(W)) sif_a ();
    squash_if #(.WIDTH(W)) sif_b ();
    squash_if #(.WIDTH(W)) sif_c ();

`ifdef SQUASH_STATS_EN
    logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

    // A: FLUSH=2 STALL=3, B: FLUSH=1 STALL=1, C: FLUSH=1 STALL=3
    squash_control #(.WIDTH(W), .FLUSH_CYCLES(2), .STALL_CYCLES(3)) u_a (
        .i_clk   (clk),
        .i_rst_n (rst_a),
`ifdef SQUASH_STATS_EN
        .o_squash_count (cnt_a),
`endif
        .sq_bus  (sif_a)
    );

    squash_control #(.WIDTH(W), .FLUSH_CYCLES(1), .STALL_CYCLES(1)) u_b (
        .i_clk   (clk),
        .i_rst_n (rst_b),
`ifdef SQUASH_STATS_EN
        .o_squash_count (cnt_b),
`endif
        .sq_bus  (sif_b)
    );

    squash_control #(.WIDTH(W), .FLUSH_CYCLES(1), .STALL_CYCLES(3)) u_c (
        .i_clk   (clk),
        .i_rst_n (rst_c),
`ifdef SQUASH_STATS_EN
        .o_squash_count (cnt_c),
`endif
        .sq_bus  (sif_c)
    );

    typedef struct {
        int           dut;
        logic         sq;
        logic         st;
        logic [W-1:0] held;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int d, output logic sq, output logic st,
                           output logic bz, output logic [W-1:0] held);
        case (d)
            0:       begin sq = sif_a.o_squash; st = sif_a.o_stall; bz = sif_a.o_busy; held = sif_a.o_held_instr; end
            1:       begin sq = sif_b.o_squash; st = sif_b.o_stall; bz = sif_b.o_busy; held = sif_b.o_held_instr; end
            default: begin sq = sif_c.o_squash; st = sif_c.o_stall; bz = sif_c.o_busy; held = sif_c.o_held_instr; end
        endcase
    endtask

    task automatic idle_all();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        sif_a.i_redirect = 1'b0; sif_a.i_load_use = 1'b0; sif_a.i_instr = '0;
        sif_b.i_redirect = 1'b0; sif_b.i_load_use = 1'b0; sif_b.i_instr = '0;
        sif_c.i_redirect = 1'b0; sif_c.i_load_use = 1'b0; sif_c.i_instr = '0;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic sb_compare();
        exp_t         e;
        logic         sq, st, bz;
        logic [W-1:0] held;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed=0 entries expected=1");
        end else begin
            e = sb.pop_front();
            get_obs(e.dut, sq, st, bz, held);
            chk({e.tag, ".squash"}, 32'(sq),   32'(e.sq));
            chk({e.tag, ".stall"},  32'(st),   32'(e.st));
            chk({e.tag, ".busy"},   32'(bz),   32'(e.sq));
            chk({e.tag, ".held"},   32'(held), 32'(e.held));
        end
    endtask

    // One clock of stimulus on DUT d; the expectation describes outputs after
    // the edge that samples this stimulus.
    task automatic step(input int d, input logic rs, input logic rd, input logic lu,
                        input logic [W-1:0] ins, input logic e_sq, input logic e_st,
                        input logic [W-1:0] e_held, input string tag);
        exp_t e;
        idle_all();
        case (d)
            0:       begin rst_a = rs; sif_a.i_redirect = rd; sif_a.i_load_use = lu; sif_a.i_instr = ins; end
            1:       begin rst_b = rs; sif_b.i_redirect = rd; sif_b.i_load_use = lu; sif_b.i_instr = ins; end
            default: begin rst_c = rs; sif_c.i_redirect = rd; sif_c.i_load_use = lu; sif_c.i_instr = ins; end
        endcase
        e.dut = d; e.sq = e_sq; e.st = e_st; e.held = e_held; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    initial begin
        logic         sq, st, bz;
        logic [W-1:0] held;

        idle_all();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            get_obs(d, sq, st, bz, held);
            chk($sformatf("init%0d.squash", d), 32'(sq),   32'd0);
            chk($sformatf("init%0d.stall",  d), 32'(st),   32'd0);
            chk($sformatf("init%0d.busy",   d), 32'(bz),   32'd0);
            chk($sformatf("init%0d.held",   d), 32'(held), 32'd0);
        end

        // --- A: reset for two edges in the middle of a 3-cycle stall
        step(0, 1, 0, 1, 17'h0ABCD, 1, 1, 17'h0ABCD, "a_stall_enter");
        step(0, 1, 0, 0, 17'h00000, 1, 1, 17'h0ABCD, "a_stall_mid");
        step(0, 0, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_rst1");
        step(0, 0, 0, 1, 17'h11111, 0, 0, 17'h00000, "a_rst2");
        step(0, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_post_rst");

        // --- A: single 2-cycle flush
        step(0, 1, 1, 0, 17'h00000, 1, 0, 17'h00000, "a_flush_c1");
        step(0, 1, 0, 0, 17'h00000, 1, 0, 17'h00000, "a_flush_c2");
        step(0, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_flush_end");

        // --- A: load-use ignored mid flush and dropped on the last flush cycle
        step(0, 1, 1, 0, 17'h00000, 1, 0, 17'h00000, "a_fl2_c1");
        step(0, 1, 0, 1, 17'h05555, 1, 0, 17'h00000, "a_fl2_lu_ignored");
        step(0, 1, 0, 1, 17'h06666, 0, 0, 17'h00000, "a_fl2_lu_last_drop");

        // --- A: redirect on the last flush cycle extends with no RUN gap
        step(0, 1, 1, 0, 17'h00000, 1, 0, 17'h00000, "a_ext_c1");
        step(0, 1, 0, 0, 17'h00000, 1, 0, 17'h00000, "a_ext_c2");
        step(0, 1, 1, 0, 17'h00000, 1, 0, 17'h00000, "a_ext_retrig");
        step(0, 1, 0, 0, 17'h00000, 1, 0, 17'h00000, "a_ext_c4");
        step(0, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_ext_end");

        // --- B: one-cycle load-use stall with capture
        step(1, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "b_idle");
        step(1, 1, 0, 1, 17'h1A5C3, 1, 1, 17'h1A5C3, "b_lu_stall");
        step(1, 1, 0, 0, 17'h00000, 0, 0, 17'h1A5C3, "b_lu_end");
        // Load-use on the last (only) stall cycle is dropped, no recapture
        step(1, 1, 0, 1, 17'h0BEEF, 1, 1, 17'h0BEEF, "b_lu2_stall");
        step(1, 1, 0, 1, 17'h00001, 0, 0, 17'h0BEEF, "b_lu2_last_drop");
        // Simultaneous redirect and load-use in RUN: flush only
        step(1, 1, 1, 1, 17'h000FF, 1, 0, 17'h0BEEF, "b_simul");
        step(1, 1, 0, 0, 17'h00000, 0, 0, 17'h0BEEF, "b_simul_end");
        // Fresh load-use in RUN is honoured
        step(1, 1, 0, 1, 17'h12345, 1, 1, 17'h12345, "b_lu3_stall");
        step(1, 1, 0, 0, 17'h00000, 0, 0, 17'h12345, "b_lu3_end");

        // --- C: redirect aborts a 3-cycle stall
        step(2, 1, 0, 1, 17'h00777, 1, 1, 17'h00777, "c_abort_stall");
        step(2, 1, 1, 0, 17'h00000, 1, 0, 17'h00777, "c_abort_flush");
        step(2, 1, 0, 0, 17'h00000, 0, 0, 17'h00777, "c_abort_run");
        // Full 3-cycle stall; re-asserted load-use does not recapture
        step(2, 1, 0, 1, 17'h1FFFF, 1, 1, 17'h1FFFF, "c_stall_c1");
        step(2, 1, 0, 0, 17'h00000, 1, 1, 17'h1FFFF, "c_stall_c2");
        step(2, 1, 0, 1, 17'h00003, 1, 1, 17'h1FFFF, "c_stall_c3_relu");
        step(2, 1, 0, 0, 17'h00000, 0, 0, 17'h1FFFF, "c_stall_end");
        // Reset beats redirect mid flush
        step(2, 1, 1, 0, 17'h00000, 1, 0, 17'h1FFFF, "c_rf_flush");
        step(2, 0, 1, 0, 17'h00000, 0, 0, 17'h00000, "c_rf_reset");
        step(2, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "c_rf_idle");

`ifdef SQUASH_STATS_EN
        step(0, 0, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_stats_rst");
        chk("stats_cleared", 32'(cnt_a), 32'd0);
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 1, 0, 17'h00000, 1, 0, 17'h00000, "a_stats_p1");
            step(0, 1, 0, 0, 17'h00000, 1, 0, 17'h00000, "a_stats_p2");
            step(0, 1, 0, 0, 17'h00000, 0, 0, 17'h00000, "a_stats_p3");
        end
        chk("stats_three_flushes", 32'(cnt_a), 32'd6);
        idle_all();
        for (int i = 0; i < 65540; i++) begin
            sif_a.i_redirect = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("stats_saturate", 32'(cnt_a), 32'h0000FFFF);
        idle_all();
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed=%0d entries expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/squash_control.md
# squash_control

Sequential hazard controller for the single-cycle CPU datapath that drives the zero-select line of the instruction input-or-zero mux. It decides when the 17-bit instruction word is replaced by zero (a bubble), for a taken redirect (flush) or a load-use hazard (stall plus bubble). It also holds the stalled instruction word so the fetch side can re-issue it.

## Interface
- WIDTH, 17, instruction word width; must match the mux data width.
- FLUSH_CYCLES, 1, bubble cycles per redirect; legal range 1..15.
- STALL_CYCLES, 1, stall/bubble cycles per load-use hazard; legal range 1..15.

Ports:
- Clock  in  1  rising-edge clock; sole clock.
- Reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- Redirect  in  1  taken branch or jump this cycle; level, sampled each edge.
- LoadUse  in  1  load-use hazard detected this cycle; level, sampled each edge.
- InstrIn  in  WIDTH  current fetched instruction word.
- Squash  out  1  drives the mux Selection; 1 = output zero.
- Stall  out  1  hold PC/fetch; 1 only in STALL.
- HeldInstr  out  WIDTH  instruction captured at stall entry.
- Busy  out  1  state != RUN.

## Operation
- FSM states: RUN, FLUSH, STALL. One 4-bit down-counter `cnt`.
- RUN:
  - Redirect=1 → FLUSH, cnt=FLUSH_CYCLES-1.
  - Else LoadUse=1 → STALL, cnt=STALL_CYCLES-1, HeldInstr<=InstrIn.
  - Else stay.
- FLUSH:
  - Redirect=1 → restart, cnt=FLUSH_CYCLES-1.
  - Else cnt==0 → RUN.
  - Else cnt-1.
  - LoadUse ignored.
- STALL:
  - Redirect=1 → FLUSH, cnt=FLUSH_CYCLES-1. Stall drops; HeldInstr unchanged.
  - Else cnt==0 → RUN.
  - Else cnt-1.
  - LoadUse re-assertion ignored; no recapture.
- Priority: Reset_n=0 > Redirect > LoadUse.
- Outputs are registered and decoded from state:
  - Squash = (FLUSH|STALL).
  - Stall = STALL.
  - Busy = Squash.
- HeldInstr loads only on RUN→STALL; otherwise it holds.

## Timing
- Reset (Reset_n=0 at an edge) forces state=RUN, cnt=0, Squash=0, Stall=0, Busy=0, HeldInstr=0. It applies mid-flush or mid-stall with no residual bubble.
- Latency: event sampled at edge k → Squash=1 from edge k+1.
- FLUSH lasts exactly FLUSH_CYCLES cycles absent re-trigger; Squash falls at edge k+FLUSH_CYCLES+1.
- STALL lasts exactly STALL_CYCLES cycles; Stall and Squash fall together.
- Back-to-back:
  - Redirect on the last FLUSH cycle extends FLUSH with no RUN gap.
  - LoadUse on the last cycle of FLUSH or STALL is dropped. The hazard unit re-asserts it in RUN.
- Simultaneous Redirect and LoadUse in RUN: FLUSH only; HeldInstr not loaded.

## Configuration
- SQUASH_STATS_EN defined:
  - Adds output port SquashCount (out, 16).
  - It is a saturating count of cycles with Squash=1; it holds at 16'hFFFF.
  - Cleared by Reset_n=0.
- SQUASH_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset: Reset_n=0 for 2 edges mid-STALL (STALL_CYCLES=3) → next cycle Squash=0, Stall=0, Busy=0, HeldInstr=17'h0.
- Single flush: FLUSH_CYCLES=2, Redirect pulse at edge 5 → Squash=1 cycles 6–7, 0 at 8; Stall=0 throughout.
- Load-use: STALL_CYCLES=1, InstrIn=17'h1A5C3, LoadUse pulse at edge 10 → Stall=Squash=1 for cycle 11 only, HeldInstr=17'h1A5C3 from cycle 11.
- Redirect aborts stall: STALL_CYCLES=3, LoadUse at edge 4, Redirect at edge 5, FLUSH_CYCLES=1 → Stall 1 only in cycle 5; Squash 1 cycles 5–6; RUN at 7.
- Simultaneous events: Redirect=LoadUse=1 at edge 3 with InstrIn=17'h00FF → FLUSH only; Stall stays 0; HeldInstr keeps its prior value.
- Stats (SQUASH_STATS_EN): 3 Redirect pulses with FLUSH_CYCLES=2, non-overlapping → SquashCount=6; a forced 65540 squash cycles → SquashCount=16'hFFFF.
